// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped, tagged branch target buffer with saturating
//               direction counters; valid bits self-clear after reset.
// Revision    : 1.0
// ============================================================================

module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8,
  parameter int PC_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict,
  output logic                ready,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
);

  localparam int c_IDX_BITS = $clog2(ENTRIES);
  localparam int c_TAG_LSB  = c_IDX_BITS + 2;
  localparam int c_TAG_MSB  = c_IDX_BITS + TAG_BITS + 1;
  localparam logic [c_IDX_BITS-1:0] c_LAST_IDX = c_IDX_BITS'(ENTRIES - 1);
  localparam logic [c_IDX_BITS-1:0] c_IDX_ONE  = c_IDX_BITS'(1);
  localparam logic [CTR_BITS-1:0]   c_CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   c_CTR_MIN  = '0;
  localparam logic [CTR_BITS-1:0]   c_CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0]   c_CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_IDX_BITS-1:0] r_init_idx;

  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [PC_WIDTH-1:0]   r_target [ENTRIES];
  logic [CTR_BITS-1:0]   r_ctr    [ENTRIES];

  logic [31:0]           r_stat_upd;
  logic [31:0]           r_stat_misp;

  logic                  w_ready;
  logic [c_IDX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic                  w_lk_hit;
  logic [c_IDX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0]   w_up_tag;
  logic                  w_up_hit;
  logic                  w_upd_acc;
  logic                  w_alloc;
  logic [CTR_BITS-1:0]   w_up_ctr;
  logic [CTR_BITS-1:0]   w_ctr_nxt;
  logic                  w_unused;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_INIT: begin
        if (r_init_idx == c_LAST_IDX) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_idx <= '0;
    end else if (r_state == S_INIT) begin
      r_init_idx <= r_init_idx + c_IDX_ONE;
    end
  end

  // ----------------------------------------------------------------- lookup
  assign w_lk_idx    = lookup_pc[c_IDX_BITS+1:2];
  assign w_lk_tag    = lookup_pc[c_TAG_MSB:c_TAG_LSB];
  assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign pred_taken  = w_ready && w_lk_hit && r_ctr[w_lk_idx][CTR_BITS-1];
  assign pred_target = r_target[w_lk_idx];

  // ----------------------------------------------------------------- update
  assign w_up_idx  = upd_pc[c_IDX_BITS+1:2];
  assign w_up_tag  = upd_pc[c_TAG_MSB:c_TAG_LSB];
  assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_upd_acc = upd_valid && w_ready && !rst;
  assign w_alloc   = w_upd_acc && !w_up_hit && upd_taken;
  assign w_up_ctr  = r_ctr[w_up_idx];

  always_comb begin
    w_ctr_nxt = w_up_ctr;
    if (upd_taken) begin
      if (w_up_ctr != c_CTR_MAX) begin
        w_ctr_nxt = w_up_ctr + c_CTR_ONE;
      end
    end else if (w_up_ctr != c_CTR_MIN) begin
      w_ctr_nxt = w_up_ctr - c_CTR_ONE;
    end
  end

  // Valid bits are the only reset-visible table state; the sweep clears them.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_valid[r_init_idx] <= 1'b0;
    end else if (w_alloc) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_upd_acc) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_nxt;
        if (upd_taken) begin
          r_target[w_up_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= upd_target;
        r_ctr[w_up_idx]    <= c_CTR_WEAK;
      end
    end
  end

  // ------------------------------------------------------------- statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_upd  <= '0;
      r_stat_misp <= '0;
    end else if (w_upd_acc) begin
      r_stat_upd <= r_stat_upd + 32'd1;
      if (upd_mispredict) begin
        r_stat_misp <= r_stat_misp + 32'd1;
      end
    end
  end

  assign ready            = w_ready;
  assign stat_updates     = r_stat_upd;
  assign stat_mispredicts = r_stat_misp;

  // Offset and high PC bits take no part in indexing or tagging.
  assign w_unused = ^{lookup_pc[PC_WIDTH-1:c_TAG_MSB+1], lookup_pc[1:0],
                      upd_pc[PC_WIDTH-1:c_TAG_MSB+1], upd_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor (64 entries, 2-bit ctr).
// Revision    : 1.0
// ============================================================================

module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [63:0] lookup_pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_mispredict;
  logic        ready;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_upd;
  logic [31:0] exp_misp;

  typedef struct {
    logic        taken;
    logic [63:0] target;
  } exp_t;

  typedef struct {
    logic [63:0] lpc;
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic [63:0] utg;
    logic        et;
    logic [63:0] etg;
  } step_t;

  exp_t sb[$];

  branch_predictor #(
    .ENTRIES (64),
    .CTR_BITS(2),
    .TAG_BITS(8),
    .PC_WIDTH(64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc       (lookup_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_mispredict  (upd_mispredict),
    .ready           (ready),
    .stat_updates    (stat_updates),
    .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Drives one cycle of stimulus and records the prediction it must produce.
  task automatic drive(input logic [63:0] lpc, input logic uv, input logic [63:0] upc,
                       input logic ut, input logic [63:0] utg, input logic um,
                       input logic et, input logic [63:0] etg);
    exp_t e;
    @(posedge clk); #1;
    lookup_pc      = lpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utg;
    upd_mispredict = um;
    e.taken  = et;
    e.target = etg;
    sb.push_back(e);
    if (uv) begin
      exp_upd = exp_upd + 32'd1;
      if (um) exp_misp = exp_misp + 32'd1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst            = 1'b1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    exp_upd  = '0;
    exp_misp = '0;
    sb.delete();
  endtask

  // Counts cycles until ready, optionally pulsing taken updates the whole time.
  task automatic wait_ready(input logic [63:0] lpc, input logic pulse,
                            output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    lookup_pc      = lpc;
    upd_pc         = lpc;
    upd_taken      = 1'b1;
    upd_target     = 64'h123;
    upd_valid      = pulse;
    upd_mispredict = pulse;
    while (ready !== 1'b1 && n < 200) begin
      if (pred_taken !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    do_reset();
    checks++;
    if (ready !== 1'b0 || pred_taken !== 1'b0 || stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b pred=%b upd=%h misp=%h, required 0 0 0 0",
               ready, pred_taken, stat_updates, stat_mispredicts);
    end
    wait_ready(64'h100, 1'b1, n, seen);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL init_length: ready after %0d cycles, required 64", n);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL init_pred: pred_taken=1 seen during INIT, required 0");
    end
    @(negedge clk);
    checks++;
    if (stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL init_updates_ignored: upd=%0d misp=%0d, required 0 0", stat_updates, stat_mispredicts);
    end
  endtask

  task automatic test_cold_miss();
    step_t s[2] = '{
      '{64'h100, 1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 64'h0},
      '{64'h100, 1'b0, 64'h0,   1'b0, 64'h0,  1'b1, 64'h80}
    };
    exp_t e;
    foreach (s[i]) begin
      drive(s[i].lpc, s[i].uv, s[i].upc, s[i].ut, s[i].utg, s[i].uv && (s[i].et != s[i].ut), s[i].et, s[i].etg);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pred_taken !== e.taken || (e.taken && pred_target !== e.target)) begin
        errors++;
        $display("FAIL cold_miss[%0d]: pred=%b tgt=%h, required %b %h", i, pred_taken, pred_target, e.taken, e.target);
      end
    end
    checks++;
    if (stat_updates !== 32'd1 || stat_mispredicts !== exp_misp) begin
      errors++;
      $display("FAIL cold_miss_stats: upd=%0d misp=%0d, required 1 %0d", stat_updates, stat_mispredicts, exp_misp);
    end
  endtask

  task automatic test_saturation();
    // counter 2 -> 1 -> 0 -> 0 -> 1 -> 2; not-taken targets must not stick
    step_t s[6] = '{
      '{64'h100, 1'b1, 64'h100, 1'b0, 64'hDEAD, 1'b1, 64'h80},
      '{64'h100, 1'b1, 64'h100, 1'b0, 64'hDEAD, 1'b0, 64'h0},
      '{64'h100, 1'b1, 64'h100, 1'b0, 64'hDEAD, 1'b0, 64'h0},
      '{64'h100, 1'b1, 64'h100, 1'b1, 64'h80,   1'b0, 64'h0},
      '{64'h100, 1'b1, 64'h100, 1'b1, 64'h90,   1'b0, 64'h0},
      '{64'h100, 1'b0, 64'h0,   1'b0, 64'h0,    1'b1, 64'h90}
    };
    exp_t e;
    foreach (s[i]) begin
      drive(s[i].lpc, s[i].uv, s[i].upc, s[i].ut, s[i].utg, s[i].uv && (s[i].et != s[i].ut), s[i].et, s[i].etg);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pred_taken !== e.taken || (e.taken && pred_target !== e.target)) begin
        errors++;
        $display("FAIL saturation[%0d]: pred=%b tgt=%h, required %b %h", i, pred_taken, pred_target, e.taken, e.target);
      end
    end
  endtask

  task automatic test_back_to_back();
    // aliasing replace, same-cycle no-bypass, not-taken miss leaves entry alone
    step_t s[9] = '{
      '{64'h4100, 1'b1, 64'h4100, 1'b1, 64'h300, 1'b0, 64'h0},
      '{64'h100,  1'b0, 64'h0,    1'b0, 64'h0,   1'b0, 64'h0},
      '{64'h4100, 1'b0, 64'h0,    1'b0, 64'h0,   1'b1, 64'h300},
      '{64'h200,  1'b1, 64'h200,  1'b1, 64'h240, 1'b0, 64'h0},
      '{64'h200,  1'b0, 64'h0,    1'b0, 64'h0,   1'b1, 64'h240},
      '{64'h203,  1'b0, 64'h0,    1'b0, 64'h0,   1'b1, 64'h240},
      '{64'h500,  1'b1, 64'h500,  1'b0, 64'h600, 1'b0, 64'h0},
      '{64'h500,  1'b0, 64'h0,    1'b0, 64'h0,   1'b0, 64'h0},
      '{64'h200,  1'b0, 64'h0,    1'b0, 64'h0,   1'b1, 64'h240}
    };
    exp_t e;
    foreach (s[i]) begin
      drive(s[i].lpc, s[i].uv, s[i].upc, s[i].ut, s[i].utg, s[i].uv && (s[i].et != s[i].ut), s[i].et, s[i].etg);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pred_taken !== e.taken || (e.taken && pred_target !== e.target)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: pred=%b tgt=%h, required %b %h", i, pred_taken, pred_target, e.taken, e.target);
      end
    end
    checks++;
    if (stat_updates !== exp_upd || stat_mispredicts !== exp_misp) begin
      errors++;
      $display("FAIL b2b_stats: upd=%0d misp=%0d, required %0d %0d", stat_updates, stat_mispredicts, exp_upd, exp_misp);
    end
  endtask

  task automatic test_stats_reset();
    exp_t e;
    int   n;
    bit   seen;
    @(posedge clk); #1;
    force dut.r_stat_misp = 32'hFFFF_FFFF;
    #2;
    release dut.r_stat_misp;
    exp_misp = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (stat_mispredicts !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stat_preload: misp=%h, required ffffffff", stat_mispredicts);
    end
    drive(64'h200, 1'b1, 64'h200, 1'b1, 64'h240, 1'b1, 1'b1, 64'h240);
    drive(64'h200, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h240);
    @(negedge clk);
    e = sb.pop_front();
    e = sb.pop_front();
    checks++;
    if (stat_mispredicts !== 32'd0 || stat_mispredicts !== exp_misp || stat_updates !== exp_upd) begin
      errors++;
      $display("FAIL stat_wrap: misp=%h upd=%0d, required 0 %0d", stat_mispredicts, stat_updates, exp_upd);
    end
    checks++;
    if (pred_taken !== e.taken || pred_target !== e.target) begin
      errors++;
      $display("FAIL wrap_pred: pred=%b tgt=%h, required %b %h", pred_taken, pred_target, e.taken, e.target);
    end
    do_reset();
    checks++;
    if (ready !== 1'b0 || pred_taken !== 1'b0 || stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL run_reset: ready=%b pred=%b upd=%h misp=%h, required 0 0 0 0",
               ready, pred_taken, stat_updates, stat_mispredicts);
    end
    repeat (10) @(posedge clk);
    do_reset();
    wait_ready(64'h200, 1'b0, n, seen);
    checks++;
    if (n != 64 || seen) begin
      errors++;
      $display("FAIL init_restart: ready after %0d cycles pred_seen=%b, required 64 0", n, seen);
    end
    drive(64'h200, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (pred_taken !== e.taken) begin
      errors++;
      $display("FAIL entry_cleared: pred=%b, required %b", pred_taken, e.taken);
    end
  endtask

  task automatic test_random();
    bit          m_valid [64];
    int          m_tag   [64];
    logic [63:0] m_tgt   [64];
    int          m_ctr   [64];
    exp_t        e;
    int          n;
    bit          seen;
    do_reset();
    wait_ready(64'h0, 1'b0, n, seen);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL random_init: ready after %0d cycles, required 64", n);
    end
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    for (int k = 0; k < 300; k++) begin
      int          li, lt, ui, ut_tag;
      logic [63:0] lpc, upc, utg;
      logic        uv, ut, um, et;
      li     = int'($urandom_range(0, 3));
      lt     = int'($urandom_range(0, 2));
      ui     = int'($urandom_range(0, 3));
      ut_tag = int'($urandom_range(0, 2));
      lpc    = 64'((lt << 8) | (li << 2) | int'($urandom_range(0, 3)));
      upc    = 64'((ut_tag << 8) | (ui << 2));
      utg    = 64'($urandom());
      uv     = ($urandom_range(0, 9) < 7);
      ut     = 1'($urandom_range(0, 1));
      um     = 1'($urandom_range(0, 1));
      et     = m_valid[li] && (m_tag[li] == lt) && (m_ctr[li] >= 2);
      drive(lpc, uv, upc, ut, utg, um, et, m_tgt[li]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pred_taken !== e.taken || (e.taken && pred_target !== e.target)) begin
        errors++;
        $display("FAIL random[%0d] pc=%h: pred=%b tgt=%h, required %b %h", k, lpc, pred_taken, pred_target, e.taken, e.target);
      end
      if (uv) begin
        if (m_valid[ui] && m_tag[ui] == ut_tag) begin
          if (ut) begin
            m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            m_tgt[ui] = utg;
          end else begin
            m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
          end
        end else if (ut) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = ut_tag;
          m_tgt[ui]   = utg;
          m_ctr[ui]   = 2;
        end
      end
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (stat_updates !== exp_upd || stat_mispredicts !== exp_misp) begin
      errors++;
      $display("FAIL random_stats: upd=%0d misp=%0d, required %0d %0d", stat_updates, stat_mispredicts, exp_upd, exp_misp);
    end
  endtask

  initial begin
    rst            = 1'b0;
    lookup_pc      = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
    exp_upd        = '0;
    exp_misp       = '0;
    test_reset();
    test_cold_miss();
    test_saturation();
    test_back_to_back();
    test_stats_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
